// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family.
//   clog2       : ceiling log2, usable in parameter and port-width expressions
//   FIFO_DATA_W : default word width
//   FIFO_DEPTH  : default number of entries
package fifo_pkg;

   localparam int FIFO_DATA_W = 8;
   localparam int FIFO_DEPTH  = 16;

   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage, DEPTH x DATA_W: one synchronous write port and
// one registered read port. The array itself is never reset so this block
// can be swapped for a vendor RAM macro; only the read register clears.
//   clk      : rising-edge clock
//   reset    : synchronous active-high clear of rd_data only
//   wr_en    : write strobe, wr_data stored at wr_addr
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe, mem[rd_addr] loaded into rd_data
//   rd_addr  : read address
//   rd_data  : registered read data, holds when rd_en is low
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int DATA_W = FIFO_DATA_W,
   parameter int DEPTH  = FIFO_DEPTH,
   parameter int AW     = clog2(FIFO_DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read-before-write: a read and write to the same address on one edge
   // returns the old contents, which is what the full-FIFO pass-through needs.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO on a circular buffer with a separate
// occupancy counter, programmable almost flags and error pulses.
//   clk          : rising-edge clock
//   reset        : synchronous active-high; drops all queued data
//   wr_en/din    : write request and data
//   rd_en        : read request
//   dout         : registered read data, valid one cycle after acceptance
//   full/empty   : count == DEPTH / count == 0
//   almost_full  : count >= AF_LEVEL
//   almost_empty : count <= AE_LEVEL
//   count        : occupancy 0..DEPTH
//   overflow     : one-cycle pulse for a rejected write while full
//   underflow    : one-cycle pulse for a read while empty
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int DATA_W   = FIFO_DATA_W,
   parameter int DEPTH    = FIFO_DEPTH,
   parameter int AF_LEVEL = 12,
   parameter int AE_LEVEL = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_W-1:0]     din,
   output logic [DATA_W-1:0]     dout,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [clog2(DEPTH):0] count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          wr_acc;
   logic          rd_acc;

   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);

   // A write while full is still taken when a read frees a slot on the same
   // edge. A read while empty is never taken, so there is no fall-through.
   assign wr_acc = wr_en & (~full | rd_en) & ~reset;
   assign rd_acc = rd_en & ~empty & ~reset;

   fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr),
      .wr_data (din),
      .rd_en   (rd_acc),
      .rd_addr (rd_ptr),
      .rd_data (dout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         // Power-of-two depth: pointers wrap by natural overflow.
         if (wr_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         overflow  <= wr_en & full & ~rd_en;
         underflow <= rd_en & empty;
      end
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

   logic       clk;
   logic       reset;
   logic       wr_en;
   logic       rd_en;
   logic [7:0] din;
   logic [7:0] dout;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;

   int n_checks = 0;
   int n_pass   = 0;

   sync_fifo_param #(
      .DATA_W   (8),
      .DEPTH    (16),
      .AF_LEVEL (12),
      .AE_LEVEL (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .rd_en        (rd_en),
      .din          (din),
      .dout         (dout),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // {full, empty, almost_full, almost_empty, overflow, underflow}
   typedef struct {
      logic       rst;
      logic       wr;
      logic       rd;
      logic [7:0] d;
      logic [4:0] cnt;
      logic [7:0] q;
      logic [5:0] flg;
   } vec_t;

   vec_t vecs [12];

   function automatic logic [5:0] flags();
      return {full, empty, almost_full, almost_empty, overflow, underflow};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic cyc(input logic r, input logic w, input logic rd, input logic [7:0] d);
      @(negedge clk);
      reset = r;
      wr_en = w;
      rd_en = rd;
      din   = d;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] sb [$];
   logic [7:0] nxt;
   logic [7:0] exp_q;
   int         exp_cnt;

   initial begin
      reset = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      din   = 8'h00;

      // ---------------- table-driven basics ----------------
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 8'h00, 6'b010100};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 8'h00, 6'b010101};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 8'h00, 6'b010100};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h11, 5'd1, 8'h00, 6'b000100};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h22, 5'd2, 8'h00, 6'b000100};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'h33, 5'd2, 8'h11, 6'b000100};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd1, 8'h22, 6'b000100};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 8'h33, 6'b010100};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'h44, 5'd1, 8'h33, 6'b000101};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 8'h44, 6'b010100};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 8'h44, 6'b010101};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 8'h44, 6'b010100};

      for (int i = 0; i < 12; i++) begin
         cyc(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].d);
         chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
         chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].q));
         chk($sformatf("vec%0d_flags", i), 32'(flags()), 32'(vecs[i].flg));
      end

      // ---------------- reset then idle ----------------
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 8'h00);
         chk($sformatf("idle%0d_count", i), 32'(count), 32'd0);
         chk($sformatf("idle%0d_dout", i), 32'(dout), 32'd0);
         chk($sformatf("idle%0d_flags", i), 32'(flags()), 32'(6'b010100));
      end

      // ---------------- fill 0x01..0x10 ----------------
      for (int i = 1; i <= 16; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 8'(i));
         chk($sformatf("fill%0d_count", i), 32'(count), 32'(i));
         chk($sformatf("fill%0d_af", i), 32'(almost_full), 32'(i >= 12));
         chk($sformatf("fill%0d_full", i), 32'(full), 32'(i == 16));
         chk($sformatf("fill%0d_ae", i), 32'(almost_empty), 32'(i <= 4));
      end

      // ---------------- overflow while full ----------------
      cyc(1'b0, 1'b1, 1'b0, 8'hAA);
      chk("ovf_pulse", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(count), 32'd16);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      chk("ovf_clear", 32'(overflow), 32'd0);

      // ---------------- simultaneous at full ----------------
      cyc(1'b0, 1'b1, 1'b1, 8'h11);
      chk("fullrw_dout", 32'(dout), 32'h01);
      chk("fullrw_count", 32'(count), 32'd16);
      chk("fullrw_ovf", 32'(overflow), 32'd0);
      chk("fullrw_full", 32'(full), 32'd1);

      // ---------------- drain: 0x02..0x11, 0xAA never appears ----------------
      for (int k = 0; k < 16; k++) begin
         cyc(1'b0, 1'b0, 1'b1, 8'h00);
         chk($sformatf("drain%0d_dout", k), 32'(dout), 32'(k + 2));
         chk($sformatf("drain%0d_count", k), 32'(count), 32'(15 - k));
         chk($sformatf("drain%0d_ae", k), 32'(almost_empty), 32'((15 - k) <= 4));
         chk($sformatf("drain%0d_empty", k), 32'(empty), 32'(k == 15));
      end

      // ---------------- underflow while empty ----------------
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      chk("unf_pulse", 32'(underflow), 32'd1);
      chk("unf_dout", 32'(dout), 32'h11);
      chk("unf_count", 32'(count), 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      chk("unf_clear", 32'(underflow), 32'd0);

      // ---------------- simultaneous at count=5 ----------------
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
      chk("mid_start_count", 32'(count), 32'd5);
      for (int j = 0; j < 8; j++) begin
         cyc(1'b0, 1'b1, 1'b1, 8'(8'h25 + j));
         chk($sformatf("mid%0d_dout", j), 32'(dout), 32'(8'h20 + j));
         chk($sformatf("mid%0d_count", j), 32'(count), 32'd5);
      end
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, 1'b0, 1'b1, 8'h00);
         chk($sformatf("middrain%0d_dout", k), 32'(dout), 32'(8'h28 + k));
      end
      chk("middrain_empty", 32'(empty), 32'd1);

      // ---------------- wrap-around, 35 writes / 35 reads ----------------
      nxt = 8'h80;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b1, 1'b0, nxt);
         sb.push_back(nxt);
         nxt = nxt + 8'd1;
      end
      for (int j = 0; j < 40; j++) begin
         logic w;
         logic r;
         w = (j % 4) != 3;
         r = (j % 4) != 1;
         exp_q = dout;
         if (r) exp_q = sb.pop_front();
         cyc(1'b0, w, r, nxt);
         if (w) begin
            sb.push_back(nxt);
            nxt = nxt + 8'd1;
         end
         chk($sformatf("wrap%0d_dout", j), 32'(dout), 32'(exp_q));
         chk($sformatf("wrap%0d_count", j), 32'(count), 32'(sb.size()));
      end
      exp_cnt = sb.size();
      for (int k = 0; k < exp_cnt; k++) begin
         exp_q = sb.pop_front();
         cyc(1'b0, 1'b0, 1'b1, 8'h00);
         chk($sformatf("wrapdrain%0d_dout", k), 32'(dout), 32'(exp_q));
      end
      chk("wrap_empty", 32'(empty), 32'd1);

      // ---------------- reset mid-stream ----------------
      for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      chk("pre_rst_dout", 32'(dout), 32'h40);
      cyc(1'b0, 1'b1, 1'b0, 8'h49);
      chk("pre_rst_count", 32'(count), 32'd9);
      cyc(1'b1, 1'b1, 1'b0, 8'hEE);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_flags", 32'(flags()), 32'(6'b010100));
      chk("rst_dout", 32'(dout), 32'd0);
      cyc(1'b0, 1'b1, 1'b0, 8'h5C);
      chk("post_rst_wr_count", 32'(count), 32'd1);
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      chk("post_rst_dout", 32'(dout), 32'h5C);
      chk("post_rst_count", 32'(count), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO: next generation of the 8x16 shift-register FIFO.
- Circular buffer with read/write pointers instead of shifting storage.
- Adds concurrent read+write, occupancy count, programmable almost-full/almost-empty flags, and overflow/underflow error pulses.
- Single clock domain. Intended as the standard buffering element between producer/consumer blocks in the datapath.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; must be a power of two, >=2.
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).
- Derived (localparam): AW = log2(DEPTH); CW = AW+1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- wr_en  input  1  write request; din captured on the same edge if accepted
- rd_en  input  1  read request
- din  input  DATA_W  write data
- dout  output  DATA_W  registered read data
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_LEVEL
- almost_empty  output  1  count <= AE_LEVEL
- count  output  CW  current occupancy, 0..DEPTH
- overflow  output  1  one-cycle pulse: write requested while full and not accepted
- underflow  output  1  one-cycle pulse: read requested while empty

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port name reset.
- On a rising clk edge with reset=1:
  - wr_ptr=0, rd_ptr=0, count=0, dout=0, overflow=0, underflow=0.
  - Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? n/a : 0).
  - Memory contents are NOT cleared.
  - reset overrides any wr_en/rd_en in the same cycle; a reset mid-stream discards all queued data.
- Acceptance, evaluated on the pre-edge state:
  - wr_acc = wr_en & (!full | rd_en).
  - rd_acc = rd_en & !empty.
- Write: if wr_acc, mem[wr_ptr] <= din; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Read: if rd_acc, dout <= mem[rd_ptr]; rd_ptr <= rd_ptr+1, wrapping.
  - dout is valid the cycle after the accepting edge (latency 1).
  - dout holds its previous value when no read is accepted.
- Count update:
  - wr_acc & !rd_acc: count+1.
  - rd_acc & !wr_acc: count-1.
  - both or neither: unchanged.
- Simultaneous read and write:
  - While empty: write accepted, read rejected (no fall-through). underflow pulses; count becomes 1.
  - While full: both accepted; read returns the oldest entry; count stays DEPTH; no overflow.
  - Otherwise: both accepted; count unchanged.
- Flags: full, empty, almost_full and almost_empty are combinational decodes of the registered count. They change only the cycle after the causing edge.
- Error pulses:
  - overflow <= wr_en & full & !rd_en.
  - underflow <= rd_en & empty.
  - Both are registered and high for exactly one cycle per offending request cycle.
  - FIFO state is unchanged by the rejected operation.
- Pointer wrap: pointers are AW bits and wrap DEPTH-1 -> 0 silently. count is kept separately, so full and empty are unambiguous.
- No X propagation: dout must never go X after reset, even when reading entries never written since power-up is impossible. Underflow blocks such reads.

Decomposition:
- Package fifo_pkg:
  - clog2 function.
  - Default constants FIFO_DATA_W=8 and FIFO_DEPTH=16.
  - Shared by all FIFO variants.
- Sub-module fifo_ram:
  - Simple dual-port memory, DEPTH x DATA_W.
  - One synchronous write port and one synchronous registered read port; no reset on storage.
  - Allows later replacement by a vendor RAM macro.
- Pointer, count and flag logic stays in sync_fifo_param.

Test Plan:
- Reset then idle: after reset, empty=1, full=0, count=0, dout=0, almost_empty=1; no pulses for 10 cycles.
- Fill then drain (DEPTH=16): write 0x01..0x10 on 16 consecutive cycles.
  - full=1 and count=16 after the 16th edge; almost_full rises at count=12.
  - Then read 16: dout sequence 0x01..0x10, each one cycle after rd_en.
  - empty=1 at end; almost_empty=1 from count=4 down.
- Overflow/underflow:
  - While full, wr_en=1 with din=0xAA for 1 cycle: overflow pulses once; count stays 16; 0xAA is never read out.
  - While empty, rd_en=1: underflow pulses once; dout unchanged.
- Simultaneous ops:
  - At count=5, wr_en=rd_en=1 for 8 cycles: count stays 5; data order is preserved.
  - At full: both accepted, no overflow.
  - At empty with both asserted: count goes to 1, underflow pulses.
- Wrap-around: 40 interleaved writes/reads keeping count at 3..7. Pointers wrap at least twice; the output stream matches the input stream exactly.
- Reset mid-stream: at count=9, assert reset with wr_en=1. Next cycle count=0, empty=1, dout=0. A subsequent write of 0x5C then read returns 0x5C.
